// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer for the icestick: step-tick prescaler, debounced mode button,
// mode FSM driving rotate/bounce/blink/off on D1-D4 and a heartbeat on D5.
module led_pattern_sequencer #(
  parameter int DIV_W     = 24,
  parameter int DIV       = 12000000,
  parameter int DB_W      = 17,
  parameter int DB_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       enable,
  output logic [3:0] led,
  output logic       led_center,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_sync1, r_sync2;
  logic             r_db;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_mode_adv;
  mode_e            r_mode;
  logic [3:0]       r_led;
  logic             r_center;
  logic             r_dir_up;

  logic             w_tick;
  logic             w_db_diff;
  logic             w_db_accept;
  mode_e            w_mode_nxt;
  logic [3:0]       w_led_nxt;
  logic             w_center_nxt;
  logic             w_dir_nxt;

  // ---------------------------------------------------------------- prescaler
  assign w_tick = enable && (r_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (r_mode_adv)
        r_cnt <= '0;
      else if (enable)
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- button
  assign w_db_diff   = (r_sync2 != r_db);
  assign w_db_accept = w_db_diff && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db       <= 1'b0;
      r_db_cnt   <= '0;
      r_mode_adv <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_mode_adv <= w_db_accept && r_sync2;
      if (w_db_accept)
        r_db <= r_sync2;
      if (!w_db_diff || w_db_accept)
        r_db_cnt <= '0;
      else
        r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_ROTATE;
      r_led    <= 4'b0001;
      r_center <= 1'b0;
      r_dir_up <= 1'b1;
    end else begin
      r_mode   <= w_mode_nxt;
      r_led    <= w_led_nxt;
      r_center <= w_center_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (r_mode_adv) begin
      case (r_mode)
        MODE_ROTATE: w_mode_nxt = MODE_BOUNCE;
        MODE_BOUNCE: w_mode_nxt = MODE_BLINK;
        MODE_BLINK:  w_mode_nxt = MODE_OFF;
        MODE_OFF:    w_mode_nxt = MODE_ROTATE;
      endcase
    end
  end

  // A mode change outranks a coincident tick: the pattern restarts from its entry value.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_led_nxt    = r_led;
    w_center_nxt = r_center;
    w_dir_nxt    = r_dir_up;
    if (r_mode_adv) begin
      w_center_nxt = 1'b0;
      w_dir_nxt    = 1'b1;
      case (w_mode_nxt)
        MODE_ROTATE: w_led_nxt = 4'b0001;
        MODE_BOUNCE: w_led_nxt = 4'b0001;
        MODE_BLINK:  w_led_nxt = 4'b1111;
        MODE_OFF:    w_led_nxt = 4'b0000;
      endcase
    end else if (w_tick) begin
      w_center_nxt = ~r_center;
      case (r_mode)
        MODE_ROTATE: w_led_nxt = {r_led[2:0], r_led[3]};
        MODE_BOUNCE: begin
          if (r_dir_up) begin
            if (r_led[3]) begin
              w_led_nxt = r_led >> 1;
              w_dir_nxt = 1'b0;
            end else begin
              w_led_nxt = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_led_nxt = r_led << 1;
              w_dir_nxt = 1'b1;
            end else begin
              w_led_nxt = r_led >> 1;
            end
          end
        end
        MODE_BLINK:  w_led_nxt = ~r_led;
        MODE_OFF: begin
          w_led_nxt    = 4'b0000;
          w_center_nxt = 1'b0;
        end
      endcase
    end
  end

  assign led        = r_led;
  assign led_center = r_center;
  assign mode       = r_mode;
  assign tick       = r_tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIV=4, DB_CYCLES=3; expected values hand-derived.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       enable;
  logic [3:0] led;
  logic       led_center;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_sequencer #(
    .DIV_W    (24),
    .DIV      (4),
    .DB_W     (17),
    .DB_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .enable    (enable),
    .led       (led),
    .led_center(led_center),
    .mode      (mode),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full press with the pattern frozen: advance lands on the 6th edge after btn rises.
  task automatic press(input logic [1:0] exp_mode);
    btn = 1'b1;
    repeat (6) step();
    check("press_mode", {30'd0, mode}, {30'd0, exp_mode});
    btn = 1'b0;
    repeat (6) step();
  endtask

  logic [3:0] rot_exp    [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] bounce_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    int k;
    rst_n  = 1'b0;
    btn    = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    check("rst_led",    {28'd0, led}, 32'h1);
    check("rst_mode",   {30'd0, mode}, 32'h1);
    check("rst_center", {31'd0, led_center}, 32'h0);
    check("rst_tick",   {31'd0, tick}, 32'h0);

    // Run to led=0100 (tick high), then assert reset between edges.
    rst_n = 1'b1;
    repeat (8) step();
    check("pre_rst_led",  {28'd0, led}, 32'h4);
    check("pre_rst_tick", {31'd0, tick}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led",    {28'd0, led}, 32'h1);
    check("async_mode",   {30'd0, mode}, 32'h1);
    check("async_center", {31'd0, led_center}, 32'h0);
    check("async_tick",   {31'd0, tick}, 32'h0);
    step();
    rst_n = 1'b1;

    // ROTATE: ticks on cycles 4,8,12,16,20.
    k = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      check("rot_tick", {31'd0, tick}, {31'd0, (cyc % 4) == 0});
      if ((cyc % 4) == 0) begin
        check("rot_led",    {28'd0, led}, {28'd0, rot_exp[k]});
        check("rot_center", {31'd0, led_center}, {31'd0, (k % 2) == 0});
        k++;
      end
    end

    // Freeze with the prescaler at 2; resume needs exactly 2 enabled cycles.
    repeat (2) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_tick", {31'd0, tick}, 32'h0);
    end
    check("frz_led",    {28'd0, led}, 32'h2);
    check("frz_center", {31'd0, led_center}, 32'h1);
    enable = 1'b1;
    step();
    check("resume_tick1", {31'd0, tick}, 32'h0);
    step();
    check("resume_tick2", {31'd0, tick}, 32'h1);
    check("resume_led",   {28'd0, led}, 32'h4);
    enable = 1'b0;

    // Glitch shorter than the debounce window.
    btn = 1'b1;
    repeat (2) step();
    btn = 1'b0;
    repeat (8) step();
    check("glitch_mode", {30'd0, mode}, 32'h1);

    // Clean press: 2 sync + 3 debounce + 1 FSM.
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("lat_mode_wait", {30'd0, mode}, 32'h1);
    end
    step();
    check("lat_mode", {30'd0, mode}, 32'h2);
    check("lat_led",  {28'd0, led}, 32'h1);
    repeat (10) step();
    check("hold_mode", {30'd0, mode}, 32'h2);
    btn = 1'b0;
    repeat (6) step();
    check("release_mode", {30'd0, mode}, 32'h2);

    // BOUNCE: 8 ticks.
    enable = 1'b1;
    k = 0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      step();
      if ((cyc % 4) == 0) begin
        check("bnc_led",    {28'd0, led}, {28'd0, bounce_exp[k]});
        check("bnc_center", {31'd0, led_center}, {31'd0, (k % 2) == 0});
        k++;
      end
    end
    enable = 1'b0;

    // BLINK
    press(2'd3);
    check("blink_entry", {28'd0, led}, 32'hF);
    enable = 1'b1;
    repeat (4) step();
    check("blink_tick",   {31'd0, tick}, 32'h1);
    check("blink_led",    {28'd0, led}, 32'h0);
    check("blink_center", {31'd0, led_center}, 32'h1);
    enable = 1'b0;

    // OFF: ticks continue, LEDs stay dark.
    press(2'd0);
    check("off_entry_led",    {28'd0, led}, 32'h0);
    check("off_entry_center", {31'd0, led_center}, 32'h0);
    enable = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      check("off_tick", {31'd0, tick}, {31'd0, (cyc % 4) == 0});
      check("off_led",  {28'd0, led}, 32'h0);
      check("off_center", {31'd0, led_center}, 32'h0);
    end
    enable = 1'b0;

    // Back to ROTATE.
    press(2'd1);
    check("rot2_led",    {28'd0, led}, 32'h1);
    check("rot2_center", {31'd0, led_center}, 32'h0);

    // Collision: ticks on edges 4,8 after enable; press from edge 2 advances on edge 8.
    enable = 1'b1;
    repeat (2) step();
    btn = 1'b1;
    repeat (2) step();
    check("col_pre_led", {28'd0, led}, 32'h2);
    repeat (3) step();
    check("col_pre_mode", {30'd0, mode}, 32'h1);
    step();
    check("col_tick",   {31'd0, tick}, 32'h1);
    check("col_mode",   {30'd0, mode}, 32'h2);
    check("col_led",    {28'd0, led}, 32'h1);
    check("col_center", {31'd0, led_center}, 32'h0);
    btn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("col_gap_tick", {31'd0, tick}, 32'h0);
    end
    step();
    check("col_next_tick", {31'd0, tick}, 32'h1);
    check("col_next_led",  {28'd0, led}, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
